// File: rtl/alt_ddrx_ecc_pkg.sv
// rtl/alt_ddrx_ecc_pkg.sv - shared ECC constants: requester source tags and legal encoder width pairs
package alt_ddrx_ecc_pkg;

    localparam logic SRC_HOST  = 1'b0;
    localparam logic SRC_SCRUB = 1'b1;

    // Raw/encoded width pairs the encoder supports: 64->72 and 32->39 plus one pad bit
    localparam int NUM_WIDTH_PAIRS = 2;
    localparam int LEGAL_IN_W  [NUM_WIDTH_PAIRS] = '{64, 32};
    localparam int LEGAL_OUT_W [NUM_WIDTH_PAIRS] = '{72, 40};

    function automatic bit ecc_widths_legal(input int in_w, input int out_w);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < NUM_WIDTH_PAIRS; i++) begin
            if (LEGAL_IN_W[i] == in_w && LEGAL_OUT_W[i] == out_w) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/alt_ddrx_ecc_enc_fifo.sv
// rtl/alt_ddrx_ecc_enc_fifo.sv - first-word fall-through FIFO for encoded words, exposes its fill count
module alt_ddrx_ecc_enc_fifo #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             wr_ok;
    logic             rd_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    // A write into a full FIFO is only legal when the head leaves in the same cycle
    always_comb begin
        rd_ok    = rd_en && !empty;
        wr_ok    = wr_en && (!full || rd_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head reads zero while empty after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alt_ddrx_ecc_enc_arbiter.sv
// rtl/alt_ddrx_ecc_enc_arbiter.sv - shares one ECC encoder between host and scrub write data with credit-based output buffering
module alt_ddrx_ecc_enc_arbiter
    import alt_ddrx_ecc_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH  = 64,
    parameter int OUTPUT_DATA_WIDTH = 72,
    parameter int ENC_LATENCY       = 1,
    parameter int OUT_DEPTH         = 4,
    parameter int MAX_HOST_BURST    = 8
) (
    input  logic                         ctl_clk,
    input  logic                         ctl_reset_n,
    input  logic                         host_valid,
    input  logic [INPUT_DATA_WIDTH-1:0]  host_data,
    output logic                         host_ready,
    input  logic                         scrub_valid,
    input  logic [INPUT_DATA_WIDTH-1:0]  scrub_data,
    output logic                         scrub_ready,
    output logic [INPUT_DATA_WIDTH-1:0]  enc_input_data,
    input  logic [OUTPUT_DATA_WIDTH-1:0] enc_output_data,
    output logic                         out_valid,
    output logic [OUTPUT_DATA_WIDTH-1:0] out_data,
    output logic                         out_src,
    input  logic                         out_ready,
    output logic                         scrub_starved
);

    localparam int CNT_W   = $clog2(OUT_DEPTH + 1);
    localparam int SUM_W   = $clog2(OUT_DEPTH + ENC_LATENCY + 1);
    localparam int BURST_W = 8;
    localparam int ENTRY_W = OUTPUT_DATA_WIDTH + 1;

    if (!ecc_widths_legal(INPUT_DATA_WIDTH, OUTPUT_DATA_WIDTH)) begin : g_bad_widths
        $error("alt_ddrx_ecc_enc_arbiter: unsupported data width pair");
    end

    logic [ENC_LATENCY-1:0]      tag_vld_q, tag_vld_d;
    logic [ENC_LATENCY-1:0]      tag_src_q, tag_src_d;
    logic [BURST_W-1:0]          burst_q, burst_d;
    logic [INPUT_DATA_WIDTH-1:0] enc_data_q, enc_data_d;
    logic [CNT_W-1:0]            fifo_count;
    logic [SUM_W-1:0]            inflight;
    logic                        issue_ok;
    logic                        burst_full;
    logic                        grant_host;
    logic                        grant_scrub;
    logic                        fifo_empty;
    logic [ENTRY_W-1:0]          fifo_rd_data;

    // Every issued word needs a reserved buffer slot since the encoder cannot stall
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ENC_LATENCY; i++) begin
            inflight = inflight + SUM_W'(tag_vld_q[i]);
        end
        issue_ok = ctl_reset_n &&
                   ((inflight + SUM_W'(fifo_count)) < SUM_W'(OUT_DEPTH));
    end

    // Host wins unless it has used up its burst allowance while scrub waits
    always_comb begin
        burst_full     = (burst_q == BURST_W'(MAX_HOST_BURST));
        grant_host     = issue_ok && host_valid && !(scrub_valid && burst_full);
        grant_scrub    = issue_ok && scrub_valid && !grant_host;
        host_ready     = grant_host;
        scrub_ready    = grant_scrub;
        scrub_starved  = grant_scrub && host_valid && burst_full;
        enc_input_data = grant_host  ? host_data  :
                         grant_scrub ? scrub_data : enc_data_q;
        enc_data_d     = enc_input_data;
    end

    // Consecutive host grants while scrub is waiting, saturating at the limit
    always_comb begin
        burst_d = burst_q;
        if (grant_scrub || !scrub_valid) begin
            burst_d = '0;
        end else if (grant_host && !burst_full) begin
            burst_d = burst_q + BURST_W'(1);
        end
    end

    // Tags ride alongside the encoder pipeline so the tail lines up with encoder q
    always_comb begin
        tag_vld_d[0] = grant_host || grant_scrub;
        tag_src_d[0] = grant_scrub ? SRC_SCRUB : SRC_HOST;
        for (int i = 1; i < ENC_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_src_d[i] = tag_src_q[i-1];
        end
    end

    // Arbitration and pipeline state
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            tag_vld_q  <= '0;
            tag_src_q  <= '0;
            burst_q    <= '0;
            enc_data_q <= '0;
        end else begin
            tag_vld_q  <= tag_vld_d;
            tag_src_q  <= tag_src_d;
            burst_q    <= burst_d;
            enc_data_q <= enc_data_d;
        end
    end

    alt_ddrx_ecc_enc_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (OUT_DEPTH),
        .CNT_W (CNT_W)
    ) u_out_fifo (
        .clk     (ctl_clk),
        .rst_n   (ctl_reset_n),
        .wr_en   (tag_vld_q[ENC_LATENCY-1]),
        .wr_data ({enc_output_data, tag_src_q[ENC_LATENCY-1]}),
        .rd_en   (out_valid && out_ready),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rd_data[ENTRY_W-1:1];
    assign out_src   = fifo_rd_data[0];

endmodule

// File: doc/alt_ddrx_ecc_enc_arbiter.md
# alt_ddrx_ecc_enc_arbiter

Shares the single registered ECC encoder (64→72 / 32→39+pad) between two write-data requesters in the DDR controller: the host write-data path and the scrub / read-modify-write correction path. It arbitrates requests onto the encoder input and tracks in-flight words across the fixed encoder latency. It returns encoded words, tagged with their source, through a small output buffer with valid/ready backpressure. Host traffic has priority, bounded by an anti-starvation limit for the scrubber.

## Interface
- INPUT_DATA_WIDTH, 64, raw data width (64 or 32)
- OUTPUT_DATA_WIDTH, 72, encoded width (72 or 40)
- ENC_LATENCY, 1, encoder input→q latency in ctl_clk cycles (1..3)
- OUT_DEPTH, 4, output buffer entries (power of two, ≥ ENC_LATENCY+1)
- MAX_HOST_BURST, 8, consecutive host grants allowed while scrub is pending (1..255)

Ports:
- ctl_clk  in  1  controller clock; all logic on rising edge
- ctl_reset_n  in  1  asynchronous, active-low reset
- host_valid  in  1  host word offered
- host_data  in  INPUT_DATA_WIDTH  host raw data
- host_ready  out  1  host word accepted this cycle when high with host_valid
- scrub_valid  in  1  scrub word offered
- scrub_data  in  INPUT_DATA_WIDTH  scrub raw data
- scrub_ready  out  1  scrub word accepted this cycle
- enc_input_data  out  INPUT_DATA_WIDTH  to encoder data input
- enc_output_data  in  OUTPUT_DATA_WIDTH  from encoder q
- out_valid  out  1  encoded word available
- out_data  out  OUTPUT_DATA_WIDTH  encoded word
- out_src  out  1  0 = host, 1 = scrub
- out_ready  in  1  consumer accepts when high with out_valid
- scrub_starved  out  1  pulse: scrub grant forced by burst limit

## Operation
- Issue credit: `issue_ok = (inflight + occupancy) < OUT_DEPTH`. The encoder has no stall, so every issued word must have a reserved buffer slot.
- Grant, evaluated each cycle only when issue_ok:
  - host_valid only → host.
  - scrub_valid only → scrub.
  - Both valid → host, unless host_burst_cnt == MAX_HOST_BURST, then scrub and pulse scrub_starved.
- host_ready/scrub_ready are combinational from the grant. At most one is high; both are low when !issue_ok.
- enc_input_data = granted requester's data; it holds its last value when idle.
- host_burst_cnt:
  - +1 on a host grant while scrub_valid is high.
  - Cleared on any scrub grant, or on any cycle scrub_valid is low.
  - Saturates at MAX_HOST_BURST.
- Tag shift register, ENC_LATENCY deep, of {valid, src}, aligned with the encoder pipeline. When the tail is valid, write {enc_output_data, src} into the output FIFO.
- Output FIFO: OUT_DEPTH entries, first-word fall-through. out_valid = not empty. out_data/out_src come from the head entry.
- inflight = count of valid tags; occupancy = FIFO count.
- Simultaneous FIFO write and pop: occupancy unchanged, and data order is preserved.

## Timing
- Reset values:
  - host_ready = scrub_ready = 0 (combinational, forced by reset).
  - out_valid = 0, out_data = 0, out_src = 0, scrub_starved = 0.
  - enc_input_data = 0; counters and tags = 0; FIFO empty.
- Latency: word accepted at cycle N → out_valid at N+ENC_LATENCY+1 with an empty FIFO (1 cycle for the FIFO write). With ENC_LATENCY=1: accepted at N, out_valid at N+2.
- Throughput: 1 word/cycle sustained when out_ready stays high.
- Full condition: with OUT_DEPTH=4 and out_ready low, exactly 4 words are accepted, then both readys drop.
  - Ready returns the cycle after the first pop, since the credit is computed from registered counts.
- Reset asserted mid-operation: in-flight tags and FIFO contents are discarded, and outputs go to reset values asynchronously. There are no partial outputs after deassertion.
- out_data must stay stable while out_valid is high and out_ready is low.

## Structure
- Shared package alt_ddrx_ecc_pkg holds:
  - SRC_HOST/SRC_SCRUB constants.
  - The legal {INPUT,OUTPUT}_DATA_WIDTH pairs, used by both this block and alt_ddrx_encoder.
- One sub-module, alt_ddrx_ecc_enc_fifo: a parameterised FWFT FIFO (width OUTPUT_DATA_WIDTH+1, depth OUT_DEPTH) that exposes its count.
- The arbiter, burst counter and tag pipeline stay in the top module.
- The encoder is instantiated by the parent, not inside this block.

## Test plan
- Host only, 16 words with incrementing data, out_ready=1 → 16 outputs in order, out_src=0, first out_valid 2 cycles after the first accept.
- Both requesters always valid, MAX_HOST_BURST=8 → grant pattern of 8 host, 1 scrub repeating; scrub_starved pulses once per scrub grant.
- out_ready=0 with host valid → exactly 4 accepts, then host_ready=0 with out_data held. Raise out_ready → drains in order, and accept resumes one cycle after the first pop.
- Simultaneous push/pop at full occupancy (out_ready toggling 1/0) → no loss or duplication; the scoreboard matches the encoder reference model.
- Assert ctl_reset_n low with 3 words in flight → out_valid=0 immediately. After release, the first new word emerges at N+2 with no stale data.
- Scrub only, OUTPUT_DATA_WIDTH=40 configuration → out_src=1 on all words and out_data[39]=0.
